// File: rtl/regs_pkg.sv
// Shared types for the register-file access protocol: response status codes
// (also used by host-side decoders) and the initiator FSM state encoding.
package regs_pkg;

  localparam logic [1:0] STATUS_OK       = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'b01;
  localparam logic [1:0] STATUS_ADDR_ERR = 2'b10;

  typedef enum logic [1:0] {
    RSP_OK       = STATUS_OK,
    RSP_TIMEOUT  = STATUS_TIMEOUT,
    RSP_ADDR_ERR = STATUS_ADDR_ERR
  } rsp_status_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } regs_master_state_e;

endpackage

// File: rtl/regs_timeout_timer.sv
// Counts WAIT cycles; expired is high on the last cycle an ack may still arrive.
module regs_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/regs_master.sv
// Register-file bus initiator: one host command at a time becomes a single
// strobe, waits for the matching ack (or times out) and returns a response.
module regs_master
  import regs_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 4,
  parameter int ERR_CNT_WIDTH  = 8,
  localparam int ADDR_WIDTH    = $clog2(DATA_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]               rsp_status,
  output logic                     reg_write_en,
  output logic                     reg_read_en,
  output logic [ADDR_WIDTH-1:0]    reg_addr,
  output logic [DATA_WIDTH-1:0]    reg_write_data,
  input  logic [DATA_WIDTH-1:0]    reg_read_data,
  input  logic                     reg_data_ready,
  input  logic                     reg_write_done,
  input  logic                     err_clr,
  output logic                     busy,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  regs_master_state_e state;
  logic               wr_q;
  logic               addr_illegal;
  logic               ack;
  logic               expired;
  logic               err_inc;

  assign cmd_ready    = (state == ST_IDLE);
  assign rsp_valid    = (state == ST_RESP);
  assign busy         = (state != ST_IDLE);
  assign addr_illegal = 32'(cmd_addr) >= 32'(DATA_DEPTH);
  // Only the ack matching the latched command type is honoured.
  assign ack          = wr_q ? reg_write_done : reg_data_ready;

  always_comb begin
    err_inc = 1'b0;
    if (state == ST_IDLE && cmd_valid && addr_illegal) err_inc = 1'b1;
    if (state == ST_WAIT && !ack && expired)           err_inc = 1'b1;
  end

  regs_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == ST_ISSUE),
    .enable (state == ST_WAIT),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      wr_q           <= 1'b0;
      rsp_rdata      <= '0;
      rsp_status     <= RSP_OK;
      reg_write_en   <= 1'b0;
      reg_read_en    <= 1'b0;
      reg_addr       <= '0;
      reg_write_data <= '0;
    end else begin
      reg_write_en <= 1'b0;
      reg_read_en  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            wr_q <= cmd_write;
            if (addr_illegal) begin
              rsp_rdata  <= '0;
              rsp_status <= RSP_ADDR_ERR;
              state      <= ST_RESP;
            end else begin
              // Strobes are registered so they are high exactly during ISSUE.
              reg_addr       <= cmd_addr;
              reg_write_data <= cmd_wdata;
              reg_write_en   <= cmd_write;
              reg_read_en    <= !cmd_write;
              state          <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (ack) begin
            rsp_rdata  <= wr_q ? '0 : reg_read_data;
            rsp_status <= RSP_OK;
            state      <= ST_RESP;
          end else if (expired) begin
            rsp_rdata  <= '0;
            rsp_status <= RSP_TIMEOUT;
            state      <= ST_RESP;
          end
        end
        ST_RESP: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (err_inc && err_count != '1) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_regs_master.sv
// Directed bench for regs_master with a small register-file responder model
// (address 5 is read-only and never acks writes).
module tb_regs_master;

  localparam int DW = 8;
  localparam int DEPTH = 12;
  localparam int AW = 4;
  localparam int TO = 4;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;
  logic          reg_write_en, reg_read_en;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_write_data, reg_read_data;
  logic          reg_data_ready, reg_write_done;
  logic          err_clr = 1'b0, busy;
  logic [EW-1:0] err_count;

  int checks = 0;
  int failures = 0;

  // Responder model state
  logic [DW-1:0] mem [DEPTH];
  logic          wd_q = 1'b0, dr_q = 1'b0, inject_wd = 1'b0;
  logic [DW-1:0] rd_q = '0;
  int            wr_pulses = 0, rd_pulses = 0;
  logic [AW-1:0] lw_addr = '0;
  logic [DW-1:0] lw_data = '0;

  logic [34:0] outs;
  assign outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_status, reg_write_en,
                 reg_read_en, reg_addr, reg_write_data, busy, err_count};

  always #5 clk = ~clk;

  regs_master #(
    .DATA_WIDTH(DW),
    .DATA_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO),
    .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status),
    .reg_write_en(reg_write_en), .reg_read_en(reg_read_en), .reg_addr(reg_addr),
    .reg_write_data(reg_write_data), .reg_read_data(reg_read_data),
    .reg_data_ready(reg_data_ready), .reg_write_done(reg_write_done),
    .err_clr(err_clr), .busy(busy), .err_count(err_count)
  );

  assign reg_write_done = wd_q | inject_wd;
  assign reg_data_ready = dr_q;
  assign reg_read_data  = rd_q;

  always @(posedge clk) begin
    wd_q <= reg_write_en && (reg_addr != 4'd5);
    dr_q <= reg_read_en;
    rd_q <= reg_read_en ? mem[reg_addr] : '0;
    if (reg_write_en) begin
      wr_pulses <= wr_pulses + 1;
      lw_addr   <= reg_addr;
      lw_data   <= reg_write_data;
      if (reg_addr != 4'd5) mem[reg_addr] <= reg_write_data;
    end
    if (reg_read_en) rd_pulses <= rd_pulses + 1;
  end

  // Offer a command at a negedge, hold it until accepted, then count negedges
  // until rsp_valid is seen (1 = visible in the cycle right after acceptance).
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic clr, output int lat);
    int n;
    @(negedge clk);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1; err_clr = clr;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL cmd_accept_timeout actual=cmd_ready 0 required=1");
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0; err_clr = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== {1'b1, 34'd0}) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=%h", outs, {1'b1, 34'd0});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== {1'b1, 34'd0}) begin
      failures++;
      $display("FAIL idle_after_reset actual=%h required=%h", outs, {1'b1, 34'd0});
    end
  endtask

  task automatic test_write();
    int lat, wp0, rp0;
    wp0 = wr_pulses; rp0 = rd_pulses;
    send(1'b1, 4'd3, 8'hA5, 1'b0, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL write_latency actual=%0d required=3", lat); end
    checks++;
    if ({rsp_status, rsp_rdata} !== {2'b00, 8'h00}) begin
      failures++; $display("FAIL write_rsp actual=%b/%h required=00/00", rsp_status, rsp_rdata);
    end
    checks++;
    if (wr_pulses - wp0 !== 1 || rd_pulses - rp0 !== 0 || lw_addr !== 4'd3 || lw_data !== 8'hA5) begin
      failures++;
      $display("FAIL write_strobe actual=wr%0d rd%0d addr%0d data%h required=wr1 rd0 addr3 dataA5",
               wr_pulses - wp0, rd_pulses - rp0, lw_addr, lw_data);
    end
    checks++;
    if ({busy, cmd_ready, err_count} !== {1'b1, 1'b0, 8'd0}) begin
      failures++; $display("FAIL write_resp_state actual=%b%b/%0d required=10/0", busy, cmd_ready, err_count);
    end
    take();
  endtask

  task automatic test_read();
    int lat, wp0, rp0;
    wp0 = wr_pulses; rp0 = rd_pulses;
    send(1'b0, 4'd3, 8'h00, 1'b0, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL read_latency actual=%0d required=3", lat); end
    checks++;
    if ({rsp_status, rsp_rdata} !== {2'b00, 8'hA5}) begin
      failures++; $display("FAIL read_rsp actual=%b/%h required=00/a5", rsp_status, rsp_rdata);
    end
    checks++;
    if (rd_pulses - rp0 !== 1 || wr_pulses - wp0 !== 0) begin
      failures++; $display("FAIL read_strobe actual=rd%0d wr%0d required=rd1 wr0", rd_pulses - rp0, wr_pulses - wp0);
    end
    take();
  endtask

  task automatic test_timeout();
    int lat;
    send(1'b1, 4'd5, 8'h3C, 1'b0, lat);
    checks++;
    if (lat !== TO + 2) begin failures++; $display("FAIL timeout_latency actual=%0d required=%0d", lat, TO + 2); end
    checks++;
    if ({rsp_status, rsp_rdata, err_count} !== {2'b01, 8'h00, 8'd1}) begin
      failures++;
      $display("FAIL timeout_rsp actual=%b/%h/%0d required=01/00/1", rsp_status, rsp_rdata, err_count);
    end
    inject_wd = 1'b1;
    @(negedge clk);
    inject_wd = 1'b0;
    checks++;
    if ({rsp_valid, rsp_status, rsp_rdata, err_count} !== {1'b1, 2'b01, 8'h00, 8'd1}) begin
      failures++;
      $display("FAIL stale_ack_in_resp actual=%b/%b/%h/%0d required=1/01/00/1",
               rsp_valid, rsp_status, rsp_rdata, err_count);
    end
    take();
    @(negedge clk);
    inject_wd = 1'b1;
    @(negedge clk);
    inject_wd = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, busy, err_count} !== {1'b0, 1'b1, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL stale_ack_in_idle actual=%b%b%b/%0d required=010/1", rsp_valid, cmd_ready, busy, err_count);
    end
  endtask

  task automatic test_addr_err();
    int lat, wp0, rp0;
    wp0 = wr_pulses; rp0 = rd_pulses;
    send(1'b0, 4'd13, 8'h00, 1'b0, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL addr_err_latency actual=%0d required=1", lat); end
    checks++;
    if ({rsp_status, rsp_rdata, err_count} !== {2'b10, 8'h00, 8'd2}) begin
      failures++;
      $display("FAIL addr_err_rsp actual=%b/%h/%0d required=10/00/2", rsp_status, rsp_rdata, err_count);
    end
    take();
    checks++;
    if (wr_pulses - wp0 !== 0 || rd_pulses - rp0 !== 0) begin
      failures++; $display("FAIL addr_err_no_strobe actual=wr%0d rd%0d required=wr0 rd0", wr_pulses - wp0, rd_pulses - rp0);
    end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    send(1'b0, 4'd3, 8'h00, 1'b0, lat);
    cmd_write = 1'b1; cmd_addr = 4'd7; cmd_wdata = 8'h5A; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_status, rsp_rdata, cmd_ready} !== {1'b1, 2'b00, 8'hA5, 1'b0}) begin
        failures++;
        $display("FAIL hold_rsp_cycle%0d actual=%b/%b/%h/%b required=1/00/a5/0",
                 i, rsp_valid, rsp_status, rsp_rdata, cmd_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      failures++; $display("FAIL next_cmd_ready actual=%b%b required=10", cmd_ready, rsp_valid);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checks++;
    if ({busy, reg_write_en, reg_addr, reg_write_data} !== {1'b1, 1'b1, 4'd7, 8'h5A}) begin
      failures++;
      $display("FAIL queued_cmd_issue actual=%b%b/%0d/%h required=11/7/5a", busy, reg_write_en, reg_addr, reg_write_data);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    take();
    send(1'b0, 4'd7, 8'h00, 1'b0, lat);
    checks++;
    if ({lat[3:0], rsp_status, rsp_rdata} !== {4'd3, 2'b00, 8'h5A}) begin
      failures++; $display("FAIL queued_write_readback actual=%0d/%b/%h required=3/00/5a", lat, rsp_status, rsp_rdata);
    end
    take();
  endtask

  task automatic test_err_sat();
    int lat;
    for (int i = 0; i < 253; i++) begin
      send(1'b1, 4'd15, 8'h00, 1'b0, lat);
      take();
    end
    checks++;
    if (err_count !== 8'hFF) begin failures++; $display("FAIL err_reach_ff actual=%h required=ff", err_count); end
    send(1'b0, 4'd12, 8'h00, 1'b0, lat);
    take();
    checks++;
    if (err_count !== 8'hFF) begin failures++; $display("FAIL err_saturate actual=%h required=ff", err_count); end
    send(1'b0, 4'd14, 8'h00, 1'b1, lat);
    take();
    checks++;
    if (err_count !== 8'h00) begin failures++; $display("FAIL err_clr_priority actual=%h required=00", err_count); end
    send(1'b0, 4'd13, 8'h00, 1'b0, lat);
    take();
    checks++;
    if (err_count !== 8'h01) begin failures++; $display("FAIL err_after_clr actual=%h required=01", err_count); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 4'd5; cmd_wdata = 8'h77; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== {1'b1, 34'd0}) begin
      failures++; $display("FAIL reset_in_wait actual=%h required=%h", outs, {1'b1, 34'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TO + 3) @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, busy, err_count} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL lost_cmd_no_rsp actual=%b%b%b/%0d required=010/0", rsp_valid, cmd_ready, busy, err_count);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_addr_err();
    test_back_to_back();
    test_err_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regs_master.md
Name: regs_master

Overview:
Initiator for the register-file access protocol. It accepts one host command at a time (read/write, address, data) on a valid/ready channel and converts it into a single-cycle strobe on the register-file bus. It waits for data_ready or write_done, and returns a response with read data and status on a second valid/ready channel. Writes to read-only registers get no write_done, so a bounded timeout turns them into an error response. The block sits between the host/command decoder and register_file.

Parameters:
DATA_WIDTH, 8, register data width
DATA_DEPTH, 16, number of registers; addresses >= DATA_DEPTH are illegal
ADDR_WIDTH, $clog2(DATA_DEPTH), address width (localparam, derived)
TIMEOUT_CYCLES, 4, WAIT cycles allowed for an ack before TIMEOUT; must be >= 2
ERR_CNT_WIDTH, 8, width of the saturating error counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target register
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_status  out  2  00 OK, 01 TIMEOUT, 10 ADDR_ERR
reg_write_en  out  1  single-cycle write strobe to register file
reg_read_en  out  1  single-cycle read strobe to register file
reg_addr  out  ADDR_WIDTH  register-file address
reg_write_data  out  DATA_WIDTH  register-file write data
reg_read_data  in  DATA_WIDTH  register-file read data
reg_data_ready  in  1  read ack, one cycle after the read strobe
reg_write_done  in  1  write ack, one cycle after the write strobe; absent for read-only registers
err_clr  in  1  synchronous clear of err_count
busy  out  1  high in any state except IDLE
err_count  out  ERR_CNT_WIDTH  saturating count of non-OK responses

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - cmd_ready = 1.
  - rsp_valid = 0; rsp_rdata = 0; rsp_status = 00.
  - reg_write_en = 0; reg_read_en = 0; reg_addr = 0; reg_write_data = 0.
  - busy = 0; err_count = 0.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: cmd_ready = 1. On handshake, latch write, addr and wdata.
    - addr >= DATA_DEPTH: go to RESP with ADDR_ERR. No bus strobe.
    - Otherwise: go to ISSUE.
  - ISSUE: exactly one cycle.
    - reg_write_en (write) or reg_read_en (read) = 1. Never both.
    - reg_addr and reg_write_data hold the latched values from ISSUE through WAIT.
    - Clear the timer; go to WAIT.
  - WAIT: strobes low.
    - Write and reg_write_done: go to RESP, OK, rdata = 0.
    - Read and reg_data_ready: capture reg_read_data; go to RESP, OK.
    - Otherwise increment the timer. When timer == TIMEOUT_CYCLES-1 with no ack: go to RESP, TIMEOUT, rdata = 0.
    - Only the ack matching the command type counts. The other ack is ignored.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_status are stable until the handshake. On rsp_ready go to IDLE. cmd_ready = 0 in RESP.
- Latency, command handshake edge to rsp_valid:
  - Read or write OK: 3 cycles.
  - ADDR_ERR: 1 cycle.
  - TIMEOUT: TIMEOUT_CYCLES + 2 cycles.
- Acks outside WAIT, including stale acks after a timeout, are ignored.
- Back-to-back commands: the next cmd_ready rises the cycle after the rsp handshake. At most one outstanding command.
- err_count:
  - Increments by 1 on entry to RESP with status != OK.
  - Saturates at all-ones.
  - err_clr has priority over a same-cycle increment; the result is 0.
- Reset mid-operation: all state is abandoned immediately, outputs return to their reset values, and the pending command is lost without a response.
- rsp_ready asserted while rsp_valid = 0 has no effect. cmd_valid while cmd_ready = 0 is held by the host and not dropped.

Decomposition:
- Shared package regs_pkg:
  - rsp_status_e enum, 2 bits: RSP_OK, RSP_TIMEOUT, RSP_ADDR_ERR.
  - regs_master_state_e enum.
  - Status encoding constants shared with host-side decoders.
- One sub-module, regs_timeout_timer: clear/enable inputs, expired output, parameter TIMEOUT_CYCLES.
- The FSM, command latch and error counter stay in regs_master.

Test Plan:
- Write to addr 3, wdata 8'hA5, responder acks write_done → exactly one reg_write_en pulse with reg_addr=3, reg_write_data=A5; rsp_valid 3 cycles after accept; status OK; err_count stays 0.
- Read addr 3 after that write → one reg_read_en pulse; rsp_rdata=A5, status OK, 3-cycle latency.
- Write to read-only addr 5 (no write_done), TIMEOUT_CYCLES=4 → rsp_valid at cycle 6, status TIMEOUT, rdata 0, err_count 1; a late write_done injected after RESP changes nothing.
- DATA_DEPTH=12, read addr 13 → no strobe; rsp_valid next cycle, status ADDR_ERR; err_count increments.
- rsp_ready held low 5 cycles, then pulsed → rsp fields stable, cmd_ready low throughout; second queued command accepted the cycle after the handshake.
- err_count at FF plus another error → stays FF; err_clr coincident with an error → 0. Assert rst_n low during WAIT → all outputs at reset values immediately, busy 0.
